// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              any_valid;
    logic              winner;
    logic              ready0_c, ready1_c;
    logic              rsp0_valid_c, rsp1_valid_c;

    assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks; last_grant is tracked but unused.
    assign winner = ~req0_valid;
`else
    // Under contention the requester that did not win last time goes next.
    assign winner = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        ready0_c     = 1'b0;
        ready1_c     = 1'b0;
        rsp0_valid_c = 1'b0;
        rsp1_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready0_c     = ~winner;
                    ready1_c     = winner;
                    alu_a_d      = winner ? req1_a    : req0_a;
                    alu_b_d      = winner ? req1_b    : req0_b;
                    ctrl_d       = winner ? req1_ctrl : req0_ctrl;
                    owner_d      = winner;
                    last_grant_d = winner;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                rsp0_valid_c = ~owner_q;
                rsp1_valid_c = owner_q;
                // Only the owning requester's ready completes the response.
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    // Ready is combinational from the request, so it is masked while reset is held.
    assign req0_ready  = ready0_c & ~rst;
    assign req1_ready  = ready1_c & ~rst;
    assign rsp0_valid  = rsp0_valid_c;
    assign rsp1_valid  = rsp1_valid_c;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = ctrl_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters: requester 0 is the pipeline execute stage and requester 1 is the auxiliary address/branch unit. Each requester uses a valid/ready handshake. The block grants one requester, drives the ALU from registered operands, and captures the result. It then returns the result on that requester's response channel, with backpressure. The block sits between the requesters and the ALU instance; the ALU itself stays purely combinational and outside this block.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_result  out  WIDTH  result, shared by both response channels
- rsp_zero  out  1  zero flag, shared by both response channels
- alu_a, alu_b  out  WIDTH  to ALU
- alu_control  out  CTRL_W  to ALU
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  state is not IDLE
- owner  out  1  index of the current/last granted requester

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- **IDLE**
  - If no valid is asserted, stay in IDLE.
  - Otherwise select a winner. Assert reqW_ready combinationally for this cycle only.
  - Latch the winner's a, b and ctrl into alu_a/alu_b/alu_control. Set owner=W. Go to EXEC.
- **EXEC**
  - Register alu_result into rsp_result and alu_zero into rsp_zero. Go to RESP.
- **RESP**
  - Assert rsp{owner}_valid; the other rsp_valid stays 0.
  - On rsp{owner}_ready=1, go to IDLE. Otherwise hold, keeping result and valid stable.
- Round-robin arbitration: last_grant flips to the winner on every grant.
  - If both requesters are valid, the requester ≠ last_grant wins.
  - If only one is valid, it wins.
- req_ready is 0 in EXEC and RESP. Requests that arrive then wait; requesters must hold valid and operands stable until ready.
- Control codes are passed through unmodified. An unsupported code yields the ALU's result (0), and rsp_zero=1.
- alu_a/alu_b/alu_control hold their last value outside EXEC. No spurious toggling.

## Timing
- Reset values:
  - State IDLE, last_grant=1 (requester 0 wins the first contention), owner=0.
  - All ready/valid outputs 0.
  - rsp_result 0, rsp_zero 0.
  - alu_a, alu_b and alu_control 0.
  - busy 0.
- Latency: request accepted at edge T, so rsp_valid is high during cycle T+2.
- Minimum interval between accepts is 3 cycles: accept, EXEC, RESP with ready=1. The next accept is possible in the cycle after the response handshake.
- rsp_ready held low: RESP persists indefinitely, with rsp_result stable.
- A rsp_ready asserted for the non-owner is ignored.
- An asynchronous rst mid-EXEC or mid-RESP discards the transaction. All outputs go to their reset values immediately; no response is delivered.
- A req_valid dropped before ready is legal and is never granted.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, where requester 0 always wins contention. last_grant is still updated but ignored.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described.

## Test plan
- **Reset:** assert rst mid-RESP -> rsp0_valid=0, busy=0, alu_control=0 the same cycle; after release, a request is granted normally.
- **Single request:** req0 ADD a=5, b=7 at T -> req0_ready=1 at T, rsp0_valid at T+2, rsp_result=12, rsp_zero=0.
- **Contention:** req0 and req1 both valid continuously, req1 SUB 9-9 -> grant order 0,1,0,1. The req1 response is rsp_result=0, rsp_zero=1, with rsp1_valid only.
- **Backpressure:** rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp_result are stable, and req0_ready stays 0 throughout. Grant to req0 comes in the cycle after rsp1_ready=1.
- **Ops:**
  - SLT 3<8 -> 1.
  - NOR 0,0 -> 0xFFFFFFFF.
  - AND 0xF0F0,0xFF00 -> 0xF000.
  - Code 4'b1111 -> 0 with zero=1.
- **Fixed priority:** with ALU_ARB_FIXED_PRIO_EN defined and both valid for 3 transactions -> requester 0 is granted all 3.
